// File: rtl/spfs_responder.sv
// spfs_responder: SPI mode-0 serial-flash responder (READ 0x03, RDID 0x9F).
// All SPI inputs are oversampled by clk_i (at least 16x SCK). Read data is
// fetched one byte ahead through a single-outstanding memory request port.
module spfs_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_clk_i,
  input  logic        spi_cs_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        mem_req_o,
  output logic [23:0] mem_addr_o,
  input  logic        mem_rdy_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic        cmd_err_o,
  output logic        underrun_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_ID     = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;

  logic [2:0]  state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [23:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [23:0] req_addr_q, req_addr_d;
  logic        pend_q, pend_d;
  logic        discard_q, discard_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        cmd_err_q, cmd_err_d;
  logic        underrun_q, underrun_d;

  logic sck_cur, sck_prev, cs_cur, cs_prev, mosi_cur;
  logic rise, fall, cs_fall, cs_rise, linked;
  logic [7:0] opcode;
  logic want_req, kill, done;

  // Input synchronisers; CS idles high so busy_o is 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    end
  end

  assign sck_cur  = sck_sync_q[SYNC_STAGES-2];
  assign sck_prev = sck_sync_q[SYNC_STAGES-1];
  assign cs_cur   = cs_sync_q[SYNC_STAGES-2];
  assign cs_prev  = cs_sync_q[SYNC_STAGES-1];
  assign mosi_cur = mosi_sync_q[SYNC_STAGES-2];

  assign linked  = ~cs_cur & (state_q != ST_IDLE);
  assign rise    = sck_cur & ~sck_prev & linked;
  assign fall    = ~sck_cur & sck_prev & linked;
  assign cs_fall = ~cs_cur & cs_prev;
  assign cs_rise = cs_cur & ~cs_prev;
  assign opcode  = {rx_q[6:0], mosi_cur};
  assign done    = req_q & mem_rdy_i;

  // Protocol FSM, shifters and the memory request/prefetch handshake.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    req_d      = req_q;
    req_addr_d = req_addr_q;
    pend_d     = pend_q;
    discard_d  = discard_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    id_idx_d   = id_idx_q;
    cmd_err_d  = 1'b0;
    underrun_d = 1'b0;
    want_req   = 1'b0;
    kill       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_CMD;
          bitcnt_d = '0;
          rx_d     = '0;
        end
      end
      ST_CMD: begin
        if (rise) begin
          rx_d     = {rx_q[22:0], mosi_cur};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = '0;
            rx_d     = '0;
            case (opcode)
              8'h03: state_d = ST_ADDR;
              8'h9F: begin
                state_d  = ST_ID;
                tx_d     = JEDEC_ID[23:16];
                id_idx_d = 2'd0;
              end
              default: begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
      end
      ST_ADDR: begin
        if (rise) begin
          rx_d     = {rx_q[22:0], mosi_cur};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd23) begin
            addr_d   = {rx_q[22:0], mosi_cur};
            bitcnt_d = '0;
            state_d  = ST_DATA;
            want_req = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rise) bitcnt_d = bitcnt_q + 5'd1;
        if (fall) begin
          if (bitcnt_q[2:0] == 3'd0) begin
            // A request still open at the boundary is for this byte and is now
            // too late: its data is dropped so it cannot land in the next slot.
            kill = 1'b1;
            if (buf_vld_q) begin
              tx_d      = buf_q;
              buf_vld_d = 1'b0;
            end else begin
              tx_d       = 8'h00;
              underrun_d = 1'b1;
            end
            addr_d   = addr_q + 24'd1;
            want_req = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_ID: begin
        if (rise) bitcnt_d = bitcnt_q + 5'd1;
        if (fall) begin
          if (bitcnt_q[2:0] == 3'd0) begin
            case (id_idx_q)
              2'd0:    tx_d = JEDEC_ID[23:16];
              2'd1:    tx_d = JEDEC_ID[15:8];
              2'd2:    tx_d = JEDEC_ID[7:0];
              default: tx_d = 8'h00;
            endcase
            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: ;
    endcase

    if (done) begin
      req_d = 1'b0;
      if (!discard_q && !kill) begin
        buf_d     = mem_rdata_i;
        buf_vld_d = 1'b1;
      end
    end

    if (req_q && !done) discard_d = discard_q | kill | cs_rise;
    else                discard_d = 1'b0;

    pend_d = (pend_q | want_req) & ~cs_rise;
    if (pend_d && (!req_q || done)) begin
      req_d      = 1'b1;
      req_addr_d = addr_d;
      pend_d     = 1'b0;
    end

    if (cs_rise) begin
      state_d   = ST_IDLE;
      buf_vld_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      pend_q     <= 1'b0;
      discard_q  <= 1'b0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      id_idx_q   <= '0;
      cmd_err_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      discard_q  <= discard_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      id_idx_q   <= id_idx_d;
      cmd_err_q  <= cmd_err_d;
      underrun_q <= underrun_d;
    end
  end

  assign spi_miso_o    = tx_q[7];
  assign spi_miso_oe_o = ((state_q == ST_DATA) || (state_q == ST_ID)) & ~cs_cur;
  assign mem_req_o     = req_q;
  assign mem_addr_o    = req_addr_q;
  assign busy_o        = ~cs_prev;
  assign cmd_err_o     = cmd_err_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spfs_responder.sv
// Self-checking bench for spfs_responder: SPI master at 16x oversampling plus
// a byte memory model that returns addr[7:0].
module tb_spfs_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk, spi_cs, spi_mosi;
  logic        spi_miso, spi_oe;
  logic        mem_req, mem_rdy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy, cmd_err, underrun;

  int checks = 0;
  int errors = 0;
  int cmd_err_cycles = 0;
  int underrun_cycles = 0;
  int next_delay = 1;
  bit hold_rdy = 1'b0;

  logic [7:0]  exp_bytes[$];
  logic [23:0] exp_addr[$];
  logic [23:0] obs_addr[$];

  always #5 clk = ~clk;

  spfs_responder #(.JEDEC_ID(24'hEF4018), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .spi_clk_i(spi_clk), .spi_cs_i(spi_cs),
    .spi_mosi_i(spi_mosi), .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_oe),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdy_i(mem_rdy),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .cmd_err_o(cmd_err),
    .underrun_o(underrun)
  );

  // Memory model and pulse counters, all evaluated on the falling clk edge.
  initial begin : mem_model
    bit active;
    int cnt, cur_delay;
    active = 0; cnt = 0; cur_delay = 1;
    mem_rdy = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_rdy = 1'b0;
        active = 0;
      end else begin
        if (mem_rdy) begin
          mem_rdy = 1'b0;
          active = 0;
        end
        if (mem_req) begin
          if (!active) begin
            active = 1;
            cnt = 0;
            obs_addr.push_back(mem_addr);
            cur_delay = next_delay;
            next_delay = 1;
          end
          cnt++;
          if (cnt >= cur_delay && !hold_rdy) begin
            mem_rdy = 1'b1;
            mem_rdata = mem_addr[7:0];
          end
        end
        if (cmd_err) cmd_err_cycles++;
        if (underrun) underrun_cycles++;
      end
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80;
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      oe_any = oe_any | spi_oe;
      oe_all = oe_all & spi_oe;
      #80;
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    spi_cs = 1'b1;
    #160;
  endtask

  task automatic spi_cmd_read(input logic [23:0] a);
    logic [7:0] rx;
    logic oa, ol;
    cs_low();
    spi_xfer(8'h03, rx, oa, ol);
    spi_xfer(a[23:16], rx, oa, ol);
    spi_xfer(a[15:8], rx, oa, ol);
    spi_xfer(a[7:0], rx, oa, ol);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    #20;
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    checks++; if (spi_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", spi_oe); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h want 000000", mem_addr); end
    checks++; if ({busy, cmd_err, underrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, cmd_err, underrun}); end
    rst_n = 1'b1;
    #40;
  endtask

  task automatic test_rdid();
    logic [7:0] rx, e;
    logic oa, ol;
    int ce0;
    obs_addr.delete(); exp_bytes.delete();
    ce0 = cmd_err_cycles;
    exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'h40);
    exp_bytes.push_back(8'h18); exp_bytes.push_back(8'h00);
    cs_low();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdid_busy got %b want 1", busy); end
    spi_xfer(8'h9F, rx, oa, ol);
    checks++; if (oa !== 1'b0) begin errors++; $display("FAIL rdid_oe_opcode got %b want 0", oa); end
    for (int k = 0; k < 4; k++) begin
      spi_xfer(8'h00, rx, oa, ol);
      e = exp_bytes.pop_front();
      checks++; if (rx !== e) begin errors++; $display("FAIL rdid_byte%0d got %h want %h", k, rx, e); end
      checks++; if (ol !== 1'b1) begin errors++; $display("FAIL rdid_oe_byte%0d got %b want 1", k, ol); end
    end
    cs_high();
    checks++; if ({spi_oe, busy} !== 2'b00) begin errors++; $display("FAIL rdid_idle got oe,busy=%b want 00", {spi_oe, busy}); end
    checks++; if (cmd_err_cycles - ce0 !== 0) begin errors++; $display("FAIL rdid_cmd_err got %0d want 0", cmd_err_cycles - ce0); end
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL rdid_mem_req got %0d requests want 0", obs_addr.size()); end
  endtask

  // READ of n bytes; first_delay applies to the ADDR-phase request only.
  task automatic test_read(input logic [23:0] base, input int n,
                           input int first_delay, input int exp_under);
    logic [7:0] rx, e;
    logic [23:0] a, o;
    logic oa, ol;
    int u0;
    obs_addr.delete(); exp_addr.delete(); exp_bytes.delete();
    u0 = underrun_cycles;
    next_delay = first_delay;
    for (int k = 0; k <= n + 1; k++) exp_addr.push_back(base + 24'(k));
    for (int k = 0; k < n; k++) begin
      a = base + 24'(k);
      exp_bytes.push_back((k == 0 && exp_under != 0) ? 8'h00 : a[7:0]);
    end
    spi_cmd_read(base);
    for (int k = 0; k < n; k++) begin
      spi_xfer(8'h00, rx, oa, ol);
      e = exp_bytes.pop_front();
      checks++; if (rx !== e) begin errors++; $display("FAIL read_%h_byte%0d got %h want %h", base, k, rx, e); end
      checks++; if (ol !== 1'b1) begin errors++; $display("FAIL read_%h_oe%0d got %b want 1", base, k, ol); end
    end
    cs_high();
    checks++; if (underrun_cycles - u0 !== exp_under) begin errors++; $display("FAIL read_%h_underrun got %0d want %0d", base, underrun_cycles - u0, exp_under); end
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL read_%h_nreq got %0d want %0d", base, obs_addr.size(), exp_addr.size()); end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      a = exp_addr.pop_front();
      o = obs_addr.pop_front();
      checks++; if (o !== a) begin errors++; $display("FAIL read_%h_addr got %h want %h", base, o, a); end
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    logic oa, ol, oe_seen;
    int ce0;
    obs_addr.delete();
    ce0 = cmd_err_cycles;
    oe_seen = 1'b0;
    cs_low();
    spi_xfer(8'h0B, rx, oa, ol);
    oe_seen = oe_seen | oa;
    for (int k = 0; k < 4; k++) begin
      spi_xfer(8'hA5, rx, oa, ol);
      oe_seen = oe_seen | oa;
    end
    cs_high();
    checks++; if (cmd_err_cycles - ce0 !== 1) begin errors++; $display("FAIL badop_cmd_err got %0d cycles want 1", cmd_err_cycles - ce0); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL badop_oe got %b want 0", oe_seen); end
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL badop_mem_req got %0d requests want 0", obs_addr.size()); end
  endtask

  task automatic test_abort();
    logic [23:0] a, o;
    obs_addr.delete(); exp_addr.delete();
    exp_addr.push_back(24'h000040); exp_addr.push_back(24'h000041);
    spi_cmd_read(24'h000040);
    hold_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #80; spi_clk = 1'b1;
      #80; spi_clk = 1'b0;
    end
    #80;
    spi_cs = 1'b1;
    #40;
    checks++; if (spi_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got %b want 0", spi_oe); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_req_held got %b want 1", mem_req); end
    #50;
    hold_rdy = 1'b0;
    #40;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_req_drop got %b want 0", mem_req); end
    #200;
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL abort_nreq got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      a = exp_addr.pop_front();
      o = obs_addr.pop_front();
      checks++; if (o !== a) begin errors++; $display("FAIL abort_addr got %h want %h", o, a); end
    end
    test_read(24'h000080, 2, 1, 0);
  endtask

  task automatic test_async_reset();
    spi_cmd_read(24'h000060);
    hold_rdy = 1'b1;
    #30;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req got %b want 1", mem_req); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b want 0", mem_req); end
    checks++; if ({spi_oe, busy, spi_miso} !== 3'b000) begin errors++; $display("FAIL arst_outs got %b want 000", {spi_oe, busy, spi_miso}); end
    #6;
    spi_cs = 1'b1; spi_clk = 1'b0; hold_rdy = 1'b0;
    #20;
    rst_n = 1'b1;
    #100;
    test_read(24'h000010, 2, 1, 0);
  endtask

  initial begin
    test_reset();
    test_rdid();
    test_read(24'h000010, 4, 1, 0);
    test_read(24'hFFFFFE, 3, 1, 0);
    test_read(24'h000020, 4, 10, 1);
    test_bad_opcode();
    test_rdid();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
